// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;  // dcache
  localparam logic PORT1 = 1'b1;  // icache

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_LINE_W = 256;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// port that did not complete the previous transaction.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req) begin
      grant = (last_grant == PORT1) ? port_onehot(PORT0) : port_onehot(PORT1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port line-memory arbiter: one outstanding transaction, round-robin on
// ties, registered outputs and an abort if memory never acknowledges.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int LINE_W         = DEFAULT_LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [LINE_W-1:0] p0_data_i,
  output logic [LINE_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_req_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [LINE_W-1:0] p1_data_i,
  output logic [LINE_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  arb_state_t         state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               last_grant_reg, last_grant_next;
  logic [1:0]         grant_reg, grant_next;
  logic [1:0]         ack_reg, ack_next;
  logic               timeout_reg, timeout_next;
  logic               mem_enable_reg, mem_enable_next;
  logic               mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
  logic [LINE_W-1:0]  mem_data_reg, mem_data_next;
  logic [1:0]         data_load;
  logic [1:0]         rr_grant;
  logic               owner;

  assign owner = grant_reg[1];

  mem_arb_rr u_rr (
    .req        ({p1_req_i, p0_req_i}),
    .last_grant (last_grant_reg),
    .grant      (rr_grant)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      last_grant_reg <= PORT1;
      grant_reg      <= '0;
      ack_reg        <= '0;
      timeout_reg    <= 1'b0;
      mem_enable_reg <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      ack_reg        <= ack_next;
      timeout_reg    <= timeout_next;
      mem_enable_reg <= mem_enable_next;
      mem_write_reg  <= mem_write_next;
      mem_addr_reg   <= mem_addr_next;
      mem_data_reg   <= mem_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    ack_next        = 2'b00;
    timeout_next    = 1'b0;
    mem_enable_next = mem_enable_reg;
    mem_write_next  = mem_write_reg;
    mem_addr_next   = mem_addr_reg;
    mem_data_next   = mem_data_reg;
    data_load       = 2'b00;

    case (state_reg)
      IDLE: begin
        if (rr_grant != 2'b00) begin
          grant_next      = rr_grant;
          timer_next      = '0;
          mem_enable_next = 1'b1;
          if (rr_grant[1]) begin
            mem_addr_next  = p1_addr_i;
            mem_data_next  = p1_data_i;
            mem_write_next = p1_write_i;
          end else begin
            mem_addr_next  = p0_addr_i;
            mem_data_next  = p0_data_i;
            mem_write_next = p0_write_i;
          end
          state_next = BUSY;
        end
      end

      BUSY: begin
        // An ack on the final timer count still completes normally.
        if (mem_ack_i) begin
          data_load       = mem_write_reg ? 2'b00 : grant_reg;
          last_grant_next = owner;
          ack_next        = grant_reg;
          mem_enable_next = 1'b0;
          mem_write_next  = 1'b0;
          timer_next      = '0;
          state_next      = RESP;
        end else if (timer_reg == TIMER_LAST) begin
          ack_next        = grant_reg;
          timeout_next    = 1'b1;
          mem_enable_next = 1'b0;
          mem_write_next  = 1'b0;
          timer_next      = '0;
          state_next      = RESP;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      RESP: begin
        grant_next = 2'b00;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-port read-data holding registers, loaded only on a read completion.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [LINE_W-1:0] data_reg;
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          data_reg <= '0;
        end else if (data_load[gi]) begin
          data_reg <= mem_data_i;
        end
      end
    end
  endgenerate

  assign p0_data_o    = g_port[0].data_reg;
  assign p1_data_o    = g_port[1].data_reg;
  assign p0_ack_o     = ack_reg[0];
  assign p1_ack_o     = ack_reg[1];
  assign mem_data_o   = mem_data_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_enable_o = mem_enable_reg;
  assign mem_write_o  = mem_write_reg;
  assign grant_o      = grant_reg;
  assign timeout_o    = timeout_reg;

endmodule
